// File: rtl/cache_pkg.sv
// Shared types and default geometry for the set-associative cache controller.
package cache_pkg;

   localparam int unsigned NUM_OF_SETS_SQRT = 2;
   localparam int unsigned INDEX_WIDTH      = 4;
   localparam int unsigned TAG_WIDTH        = 8;

   typedef logic [NUM_OF_SETS_SQRT-1:0] way_t;
   typedef logic [INDEX_WIDTH-1:0]      index_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOOKUP,
      S_WRITEBACK,
      S_REFILL,
      S_UPDATE
   } state_t;

endpackage

// File: rtl/cache_tag_array.sv
// Tag/valid/dirty storage for every set with a parallel tag compare across the ways.
module cache_tag_array
   import cache_pkg::*;
#(
   parameter int unsigned num_of_sets_sqrt = NUM_OF_SETS_SQRT,
   parameter int unsigned index_width      = INDEX_WIDTH,
   parameter int unsigned tag_width        = TAG_WIDTH
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic [index_width-1:0]      index_i,
   input  logic [tag_width-1:0]        tag_i,
   input  logic [num_of_sets_sqrt-1:0] victim_way_i,
   input  logic                        install_i,
   input  logic [num_of_sets_sqrt-1:0] install_way_i,
   input  logic                        install_dirty_i,
   input  logic                        set_dirty_i,
   output logic                        hit_o,
   output logic [num_of_sets_sqrt-1:0] hit_way_o,
   output logic [num_of_sets_sqrt-1:0] first_invalid_o,
   output logic                        all_valid_o,
   output logic [tag_width-1:0]        victim_tag_o,
   output logic                        victim_dirty_o
);

   localparam int unsigned ways = 1 << num_of_sets_sqrt;
   localparam int unsigned sets = 1 << index_width;

   logic [tag_width-1:0] tag_q   [sets][ways];
   logic [ways-1:0]      valid_q [sets];
   logic [ways-1:0]      dirty_q [sets];

   // Descending scans so the lowest-numbered matching way is the one that sticks.
   always_comb begin
      hit_o           = 1'b0;
      hit_way_o       = '0;
      first_invalid_o = '0;
      all_valid_o     = &valid_q[index_i];
      for (int w = ways - 1; w >= 0; w--) begin
         if (valid_q[index_i][w] && (tag_q[index_i][w] == tag_i)) begin
            hit_o     = 1'b1;
            hit_way_o = num_of_sets_sqrt'(w);
         end
         if (!valid_q[index_i][w]) begin
            first_invalid_o = num_of_sets_sqrt'(w);
         end
      end
      victim_tag_o   = tag_q[index_i][victim_way_i];
      victim_dirty_o = dirty_q[index_i][victim_way_i];
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         valid_q <= '{default: '0};
         dirty_q <= '{default: '0};
      end else begin
         if (install_i) begin
            valid_q[index_i][install_way_i] <= 1'b1;
            dirty_q[index_i][install_way_i] <= install_dirty_i;
         end
         if (set_dirty_i && hit_o) begin
            dirty_q[index_i][hit_way_o] <= 1'b1;
         end
      end
   end

   // Tags need no reset: a tag is only ever looked at through its valid bit.
   always_ff @(posedge clk_i) begin
      if (install_i) begin
         tag_q[index_i][install_way_i] <= tag_i;
      end
   end

endmodule

// File: rtl/cache_ctrl.sv
// Set-associative cache controller: lookup, victim choice, writeback/refill sequencing
// and a single LRU update pulse per completed access.
module cache_ctrl
   import cache_pkg::*;
#(
   parameter int unsigned num_of_sets_sqrt = NUM_OF_SETS_SQRT,
   parameter int unsigned index_width      = INDEX_WIDTH,
   parameter int unsigned tag_width        = TAG_WIDTH
) (
   input  logic                                clk_i,
   input  logic                                rst_ni,
   input  logic                                req_valid_i,
   output logic                                req_ready_o,
   input  logic                                req_write_i,
   input  logic [tag_width+index_width-1:0]    req_addr_i,
   output logic                                resp_valid_o,
   output logic                                resp_hit_o,
   output logic [num_of_sets_sqrt-1:0]         resp_way_o,
   output logic                                mem_valid_o,
   output logic                                mem_we_o,
   output logic [tag_width+index_width-1:0]    mem_addr_o,
   input  logic                                mem_done_i,
   output logic                                lru_write_en_o,
   output logic [index_width-1:0]              lru_address_o,
   output logic [num_of_sets_sqrt-1:0]         lru_set_num_o,
   input  logic [num_of_sets_sqrt-1:0]         lru_set_i
);

   localparam int unsigned addr_width = tag_width + index_width;

   // Request handshake: a request transfers on a rising edge where req_valid_i and
   // req_ready_o are both high; the requester holds address and write flag until then.

   state_t                      state_q, state_d;
   logic [addr_width-1:0]       addr_q, addr_d;
   logic                        write_q, write_d;
   logic                        hit_q, hit_d;
   logic [num_of_sets_sqrt-1:0] way_q, way_d;
   logic [tag_width-1:0]        wb_tag_q, wb_tag_d;

   logic [tag_width-1:0]        req_tag;
   logic [index_width-1:0]      req_index;
   logic                        lookup_hit;
   logic [num_of_sets_sqrt-1:0] hit_way;
   logic [num_of_sets_sqrt-1:0] first_invalid;
   logic                        all_valid;
   logic [num_of_sets_sqrt-1:0] victim_way;
   logic [tag_width-1:0]        victim_tag;
   logic                        victim_dirty;
   logic                        install_en;
   logic                        set_dirty_en;

   assign req_tag    = addr_q[addr_width-1 -: tag_width];
   assign req_index  = addr_q[index_width-1:0];
   assign victim_way = all_valid ? lru_set_i : first_invalid;

   cache_tag_array #(
      .num_of_sets_sqrt(num_of_sets_sqrt),
      .index_width     (index_width),
      .tag_width       (tag_width)
   ) u_tag_array (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .index_i        (req_index),
      .tag_i          (req_tag),
      .victim_way_i   (victim_way),
      .install_i      (install_en),
      .install_way_i  (way_q),
      .install_dirty_i(write_q),
      .set_dirty_i    (set_dirty_en),
      .hit_o          (lookup_hit),
      .hit_way_o      (hit_way),
      .first_invalid_o(first_invalid),
      .all_valid_o    (all_valid),
      .victim_tag_o   (victim_tag),
      .victim_dirty_o (victim_dirty)
   );

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q  <= S_IDLE;
         addr_q   <= '0;
         write_q  <= 1'b0;
         hit_q    <= 1'b0;
         way_q    <= '0;
         wb_tag_q <= '0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         write_q  <= write_d;
         hit_q    <= hit_d;
         way_q    <= way_d;
         wb_tag_q <= wb_tag_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      write_d  = write_q;
      hit_d    = hit_q;
      way_d    = way_q;
      wb_tag_d = wb_tag_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid_i) begin
               addr_d  = req_addr_i;
               write_d = req_write_i;
               state_d = S_LOOKUP;
            end
         end
         S_LOOKUP: begin
            if (lookup_hit) begin
               hit_d   = 1'b1;
               way_d   = hit_way;
               state_d = S_UPDATE;
            end else begin
               // Victim way and its tag are captured here so lru_set_i is not needed later.
               hit_d    = 1'b0;
               way_d    = victim_way;
               wb_tag_d = victim_tag;
               state_d  = (all_valid && victim_dirty) ? S_WRITEBACK : S_REFILL;
            end
         end
         S_WRITEBACK: begin
            if (mem_done_i) state_d = S_REFILL;
         end
         S_REFILL: begin
            if (mem_done_i) state_d = S_UPDATE;
         end
         S_UPDATE: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_comb begin
      req_ready_o    = 1'b0;
      resp_valid_o   = 1'b0;
      mem_valid_o    = 1'b0;
      mem_we_o       = 1'b0;
      mem_addr_o     = '0;
      lru_write_en_o = 1'b0;
      lru_set_num_o  = '0;
      install_en     = 1'b0;
      set_dirty_en   = 1'b0;
      case (state_q)
         S_IDLE:   req_ready_o = 1'b1;
         S_LOOKUP: set_dirty_en = write_q;
         S_WRITEBACK: begin
            mem_valid_o = 1'b1;
            mem_we_o    = 1'b1;
            mem_addr_o  = {wb_tag_q, req_index};
         end
         S_REFILL: begin
            mem_valid_o = 1'b1;
            mem_addr_o  = addr_q;
            install_en  = mem_done_i;
         end
         S_UPDATE: begin
            resp_valid_o   = 1'b1;
            lru_write_en_o = 1'b1;
            lru_set_num_o  = way_q;
         end
         default: req_ready_o = 1'b0;
      endcase
   end

   assign resp_hit_o    = hit_q;
   assign resp_way_o    = way_q;
   assign lru_address_o = req_index;

endmodule

// File: tb/tb_cache_ctrl.sv
// Directed bench for cache_ctrl: a scripted memory responder and LRU input,
// one task per scenario with hand-computed expectations.
module tb_cache_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [11:0] req_addr = '0;
  logic        mem_done = 1'b0;
  logic [1:0]  lru_set = '0;

  logic        req_ready_o;
  logic        resp_valid_o;
  logic        resp_hit_o;
  logic [1:0]  resp_way_o;
  logic        mem_valid_o;
  logic        mem_we_o;
  logic [11:0] mem_addr_o;
  logic        lru_write_en_o;
  logic [3:0]  lru_address_o;
  logic [1:0]  lru_set_num_o;

  int checks = 0;
  int failures = 0;
  int mem_lat = 0;

  int          obs_k;
  logic        obs_hit;
  logic [1:0]  obs_way;
  int          obs_wb_cnt;
  int          obs_rf_cnt;
  logic [11:0] obs_wb_addr;
  logic [11:0] obs_rf_addr;
  int          obs_lru_cnt;
  logic [3:0]  obs_lru_idx;
  logic [1:0]  obs_lru_way;

  logic [6:0]  exp_q[$];

  cache_ctrl dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .req_valid_i   (req_valid),
    .req_ready_o   (req_ready_o),
    .req_write_i   (req_write),
    .req_addr_i    (req_addr),
    .resp_valid_o  (resp_valid_o),
    .resp_hit_o    (resp_hit_o),
    .resp_way_o    (resp_way_o),
    .mem_valid_o   (mem_valid_o),
    .mem_we_o      (mem_we_o),
    .mem_addr_o    (mem_addr_o),
    .mem_done_i    (mem_done),
    .lru_write_en_o(lru_write_en_o),
    .lru_address_o (lru_address_o),
    .lru_set_num_o (lru_set_num_o),
    .lru_set_i     (lru_set)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic pulse_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Issues one request and services memory until the response; k=1 is the cycle after acceptance.
  task automatic run_access(input logic [11:0] addr, input logic wr);
    int wait_cnt;
    int guard;
    obs_k = 0; obs_hit = 1'bx; obs_way = 2'bxx;
    obs_wb_cnt = 0; obs_rf_cnt = 0; obs_wb_addr = '0; obs_rf_addr = '0;
    obs_lru_cnt = 0; obs_lru_idx = '0; obs_lru_way = '0;
    guard = 0;
    while (!req_ready_o && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    req_valid = 1'b1; req_addr = addr; req_write = wr;
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_cnt = 0;
    for (int k = 1; k <= 40; k++) begin
      if (mem_valid_o) begin
        if (mem_we_o) begin obs_wb_cnt++; obs_wb_addr = mem_addr_o; end
        else begin obs_rf_cnt++; obs_rf_addr = mem_addr_o; end
        if (wait_cnt >= mem_lat) begin mem_done = 1'b1; wait_cnt = 0; end
        else begin mem_done = 1'b0; wait_cnt++; end
      end else begin
        mem_done = 1'b0;
      end
      if (lru_write_en_o) begin
        obs_lru_cnt++; obs_lru_idx = lru_address_o; obs_lru_way = lru_set_num_o;
      end
      if (resp_valid_o) begin
        obs_k = k; obs_hit = resp_hit_o; obs_way = resp_way_o;
        mem_done = 1'b0;
        break;
      end
      @(posedge clk); #1;
    end
    mem_done = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if (req_ready_o !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b expected 1", req_ready_o); end
    checks++; if ({resp_valid_o, mem_valid_o, lru_write_en_o} !== 3'b000) begin failures++; $display("FAIL reset_strobes: got %b expected 000", {resp_valid_o, mem_valid_o, lru_write_en_o}); end
    checks++; if ({resp_hit_o, resp_way_o, mem_we_o, mem_addr_o, lru_set_num_o, lru_address_o} !== 22'h0) begin
      failures++; $display("FAIL reset_values: got %h expected 0", {resp_hit_o, resp_way_o, mem_we_o, mem_addr_o, lru_set_num_o, lru_address_o}); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_cold_miss();
    mem_lat = 0;
    run_access(12'h0C3, 1'b0);
    checks++; if (obs_k !== 3) begin failures++; $display("FAIL cold_latency: got %0d expected 3", obs_k); end
    checks++; if ({obs_hit, obs_way} !== 3'b000) begin failures++; $display("FAIL cold_resp: got hit/way %b expected 000", {obs_hit, obs_way}); end
    checks++; if (obs_rf_cnt !== 1 || obs_rf_addr !== 12'h0C3 || obs_wb_cnt !== 0) begin
      failures++; $display("FAIL cold_mem: got rf=%0d addr=%h wb=%0d expected rf=1 addr=0c3 wb=0", obs_rf_cnt, obs_rf_addr, obs_wb_cnt); end
    checks++; if (obs_lru_cnt !== 1 || obs_lru_idx !== 4'd3 || obs_lru_way !== 2'd0) begin
      failures++; $display("FAIL cold_lru: got cnt=%0d idx=%0d way=%0d expected 1/3/0", obs_lru_cnt, obs_lru_idx, obs_lru_way); end
  endtask

  task automatic test_hit();
    run_access(12'h0C3, 1'b0);
    checks++; if (obs_k !== 2) begin failures++; $display("FAIL hit_latency: got %0d expected 2", obs_k); end
    checks++; if ({obs_hit, obs_way} !== 3'b100) begin failures++; $display("FAIL hit_resp: got hit/way %b expected 100", {obs_hit, obs_way}); end
    checks++; if (obs_wb_cnt + obs_rf_cnt !== 0) begin failures++; $display("FAIL hit_no_mem: got %0d mem cycles expected 0", obs_wb_cnt + obs_rf_cnt); end
    checks++; if (obs_lru_cnt !== 1 || obs_lru_idx !== 4'd3 || obs_lru_way !== 2'd0) begin
      failures++; $display("FAIL hit_lru: got cnt=%0d idx=%0d way=%0d expected 1/3/0", obs_lru_cnt, obs_lru_idx, obs_lru_way); end
  endtask

  task automatic test_evict();
    logic [11:0] fill_addr [4];
    fill_addr[0] = 12'h013; fill_addr[1] = 12'h023; fill_addr[2] = 12'h033; fill_addr[3] = 12'h043;
    pulse_reset();
    mem_lat = 0;
    for (int i = 0; i < 4; i++) begin
      run_access(fill_addr[i], (i == 0));
      checks++; if ({obs_hit, obs_way} !== {1'b0, 2'(i)}) begin
        failures++; $display("FAIL fill_way%0d: got hit/way %b expected %b", i, {obs_hit, obs_way}, {1'b0, 2'(i)}); end
    end
    // Dirty victim in way 0, memory acknowledges immediately.
    lru_set = 2'd0;
    run_access(12'h053, 1'b0);
    checks++; if (obs_wb_cnt !== 1 || obs_wb_addr !== 12'h013) begin
      failures++; $display("FAIL evict_wb: got cnt=%0d addr=%h expected 1/013", obs_wb_cnt, obs_wb_addr); end
    checks++; if (obs_rf_cnt !== 1 || obs_rf_addr !== 12'h053) begin
      failures++; $display("FAIL evict_rf: got cnt=%0d addr=%h expected 1/053", obs_rf_cnt, obs_rf_addr); end
    checks++; if (obs_k !== 4 || {obs_hit, obs_way} !== 3'b000) begin
      failures++; $display("FAIL evict_resp: got k=%0d hit/way=%b expected 4/000", obs_k, {obs_hit, obs_way}); end
    // Write hit marks way 1 dirty; slow memory then evicts it.
    run_access(12'h023, 1'b1);
    checks++; if (obs_k !== 2 || {obs_hit, obs_way} !== 3'b101) begin
      failures++; $display("FAIL write_hit: got k=%0d hit/way=%b expected 2/101", obs_k, {obs_hit, obs_way}); end
    lru_set = 2'd1;
    mem_lat = 2;
    run_access(12'h063, 1'b0);
    checks++; if (obs_wb_cnt !== 3 || obs_wb_addr !== 12'h023 || obs_rf_cnt !== 3 || obs_rf_addr !== 12'h063) begin
      failures++; $display("FAIL slow_evict_mem: got wb=%0d/%h rf=%0d/%h expected 3/023 3/063", obs_wb_cnt, obs_wb_addr, obs_rf_cnt, obs_rf_addr); end
    checks++; if (obs_k !== 8 || {obs_hit, obs_way} !== 3'b001) begin
      failures++; $display("FAIL slow_evict_resp: got k=%0d hit/way=%b expected 8/001", obs_k, {obs_hit, obs_way}); end
    // Clean victim in way 2: no writeback.
    lru_set = 2'd2;
    mem_lat = 0;
    run_access(12'h073, 1'b0);
    checks++; if (obs_wb_cnt !== 0 || obs_rf_addr !== 12'h073 || obs_k !== 3 || obs_way !== 2'd2) begin
      failures++; $display("FAIL clean_evict: got wb=%0d rf=%h k=%0d way=%0d expected 0/073/3/2", obs_wb_cnt, obs_rf_addr, obs_k, obs_way); end
  endtask

  task automatic test_stray_done();
    mem_done = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++; if ({req_ready_o, mem_valid_o, resp_valid_o} !== 3'b100) begin
        failures++; $display("FAIL stray_done_idle: got %b expected 100", {req_ready_o, mem_valid_o, resp_valid_o}); end
    end
    mem_done = 1'b0;
    run_access(12'h053, 1'b0);
    checks++; if (obs_k !== 2 || {obs_hit, obs_way} !== 3'b100) begin
      failures++; $display("FAIL stray_done_hit: got k=%0d hit/way=%b expected 2/100", obs_k, {obs_hit, obs_way}); end
  endtask

  task automatic test_reset_mid();
    req_valid = 1'b1; req_addr = 12'h0A5; req_write = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (mem_valid_o !== 1'b1 || mem_addr_o !== 12'h0A5) begin
      failures++; $display("FAIL mid_refill: got valid=%b addr=%h expected 1/0a5", mem_valid_o, mem_addr_o); end
    rst_n = 1'b0; mem_done = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1; mem_done = 1'b0;
    checks++; if ({mem_valid_o, req_ready_o, resp_valid_o, lru_write_en_o} !== 4'b0100) begin
      failures++; $display("FAIL mid_abort: got %b expected 0100", {mem_valid_o, req_ready_o, resp_valid_o, lru_write_en_o}); end
    run_access(12'h0A5, 1'b0);
    checks++; if (obs_k !== 3 || obs_hit !== 1'b0) begin
      failures++; $display("FAIL mid_remiss: got k=%0d hit=%b expected 3/0", obs_k, obs_hit); end
  endtask

  task automatic test_back_to_back();
    logic       accept_next;
    int         n_resp;
    logic [6:0] exp_v;
    exp_q.push_back({1'b1, 2'd0, 4'd5});
    exp_q.push_back({1'b0, 2'd0, 4'd6});
    n_resp = 0;
    req_valid = 1'b1; req_addr = 12'h0A5; req_write = 1'b0;
    @(posedge clk); #1;
    req_addr = 12'h0B6;
    for (int k = 1; k <= 30; k++) begin
      mem_done = mem_valid_o;
      if (resp_valid_o) begin
        checks++; if (req_ready_o !== 1'b0) begin failures++; $display("FAIL b2b_ready_with_resp: got %b expected 0", req_ready_o); end
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL b2b_extra_resp: got %b expected none", {resp_hit_o, resp_way_o, lru_address_o});
        end else begin
          exp_v = exp_q.pop_front();
          if ({resp_hit_o, resp_way_o, lru_address_o} !== exp_v) begin
            failures++; $display("FAIL b2b_resp%0d: got %b expected %b", n_resp, {resp_hit_o, resp_way_o, lru_address_o}, exp_v);
          end
        end
        n_resp++;
      end
      accept_next = req_valid && req_ready_o;
      @(posedge clk); #1;
      if (accept_next) req_valid = 1'b0;
    end
    mem_done = 1'b0;
    req_valid = 1'b0;
    checks++; if (n_resp !== 2 || exp_q.size() != 0) begin
      failures++; $display("FAIL b2b_count: got %0d responses expected 2", n_resp); end
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_hit();
    test_evict();
    test_stray_done();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
